// File: rtl/char_column_scanner.sv
// rtl/char_column_scanner.sv - fetches a 5x7 glyph from the character ROM and streams it out column by column.
// Each glyph is followed by GAP_COLS blank spacer columns, and col_last marks the final column of the character.
module char_column_scanner #(
   parameter int DATA_WIDTH = 35,
   parameter int ROWS       = 7,
   parameter int COLS       = 5,
   parameter int GAP_COLS   = 1,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] char_code,
   input  logic                  char_valid,
   output logic                  char_ready,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [ROWS-1:0]       col_data,
   output logic                  col_valid,
   output logic                  col_last,
   input  logic                  col_ready
);

   localparam int MAXC = (COLS > GAP_COLS) ? COLS : GAP_COLS;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] COL_END = CW'(COLS - 1);
   localparam logic [CW-1:0] GAP_END = CW'((GAP_COLS > 0) ? GAP_COLS - 1 : 0);

   typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAP} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   glyph_q;
   logic [CW-1:0]           cnt_q;
   logic [ROWS-1:0]         data_q;
   logic                    valid_q;
   logic                    last_q;
   logic                    col_hs;

   // Row-major glyph, MSB is the top-left pixel; bit r of a column is row r.
   function automatic logic [ROWS-1:0] column_of(input logic [DATA_WIDTH-1:0] g,
                                                 input logic [CW-1:0] c);
      logic [ROWS-1:0] col;
      col = '0;
      for (int r = 0; r < ROWS; r++) begin
         col[r] = g[DATA_WIDTH-1-(r*COLS+int'(c))];
      end
      return col;
   endfunction

   assign char_ready = (state_q == IDLE) && !rst;
   assign rom_addr   = addr_q;
   assign col_data   = data_q;
   assign col_valid  = valid_q;
   assign col_last   = last_q;
   assign col_hs     = valid_q && col_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         glyph_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (char_valid && char_ready) begin
                  addr_q  <= char_code;
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               // Column 0 is loaded straight from the ROM so it is visible next cycle.
               glyph_q <= rom_data;
               cnt_q   <= '0;
               data_q  <= column_of(rom_data, '0);
               valid_q <= 1'b1;
               last_q  <= (GAP_COLS == 0) && (COLS == 1);
               state_q <= EMIT;
            end
            EMIT: begin
               if (col_hs) begin
                  if (cnt_q == COL_END) begin
                     cnt_q  <= '0;
                     data_q <= '0;
                     if (GAP_COLS > 0) begin
                        last_q  <= (GAP_COLS == 1);
                        state_q <= GAP;
                     end else begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     data_q <= column_of(glyph_q, cnt_q + 1'b1);
                     last_q <= (GAP_COLS == 0) && ((cnt_q + 1'b1) == COL_END);
                  end
               end
            end
            GAP: begin
               if (col_hs) begin
                  if (cnt_q == GAP_END) begin
                     cnt_q   <= '0;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     cnt_q  <= cnt_q + 1'b1;
                     last_q <= ((cnt_q + 1'b1) == GAP_END);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_char_column_scanner.sv
// tb/tb_char_column_scanner.sv - scoreboard bench for char_column_scanner with hand-coded glyph columns.
// dut0 uses one gap column; dut1 has no gap and is used for back-to-back timing.
module tb_char_column_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [6:0]  code0, addr0, code1, addr1;
   logic        cv0, cr0, cv1, cr1;
   logic [34:0] rd0, rd1;
   logic [6:0]  cd0, cd1;
   logic        cval0, clast0, crdy0, cval1, clast1;

   function automatic logic [34:0] rom(input logic [6:0] a);
      case (a)
         7'h41:   rom = 35'b01110_10001_10001_11111_10001_10001_10001;
         7'h48:   rom = 35'b10001_10001_10001_11111_10001_10001_10001;
         7'h49:   rom = 35'b01110_00100_00100_00100_00100_00100_01110;
         default: rom = (a < 7'h20) ? '1 : '0;
      endcase
   endfunction

   assign rd0 = rom(addr0);
   assign rd1 = rom(addr1);

   char_column_scanner #(.GAP_COLS(1)) dut0 (
      .clk(clk), .rst(rst), .char_code(code0), .char_valid(cv0), .char_ready(cr0),
      .rom_addr(addr0), .rom_data(rd0), .col_data(cd0), .col_valid(cval0),
      .col_last(clast0), .col_ready(crdy0)
   );

   char_column_scanner #(.GAP_COLS(0)) dut1 (
      .clk(clk), .rst(rst), .char_code(code1), .char_valid(cv1), .char_ready(cr1),
      .rom_addr(addr1), .rom_data(rd1), .col_data(cd1), .col_valid(cval1),
      .col_last(clast1), .col_ready(1'b1)
   );

   typedef struct packed {
      logic [6:0] d;
      logic       l;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   acc1[$];
   int   lst1[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   logic       stall0;
   logic [6:0] pd0;
   logic       pl0;
   initial stall0 = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall0 = 1'b0;
      end else begin
         if (cval0) chk("busy_char_ready", {31'd0, cr0}, 32'd0);
         if (stall0) begin
            chk("stall_valid", {31'd0, cval0}, 32'd1);
            chk("stall_data", {25'd0, cd0}, {25'd0, pd0});
            chk("stall_last", {31'd0, clast0}, {31'd0, pl0});
         end
         if (cval0 && crdy0) begin
            if (q0.size() == 0) begin
               chk("unexpected_col0", 32'd1, 32'd0);
            end else begin
               e = q0.pop_front();
               chk("col_data0", {25'd0, cd0}, {25'd0, e.d});
               chk("col_last0", {31'd0, clast0}, {31'd0, e.l});
            end
         end
         stall0 = cval0 && !crdy0;
         pd0    = cd0;
         pl0    = clast0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (cv1 && cr1) acc1.push_back(cyc);
         if (cval1) begin
            if (clast1) lst1.push_back(cyc);
            if (q1.size() == 0) begin
               chk("unexpected_col1", 32'd1, 32'd0);
            end else begin
               e = q1.pop_front();
               chk("col_data1", {25'd0, cd1}, {25'd0, e.d});
               chk("col_last1", {31'd0, clast1}, {31'd0, e.l});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [6:0] c0, c1, c2, c3, c4);
      q0.push_back({c0, 1'b0});
      q0.push_back({c1, 1'b0});
      q0.push_back({c2, 1'b0});
      q0.push_back({c3, 1'b0});
      q0.push_back({c4, 1'b0});
      q0.push_back({7'h00, 1'b1});
   endtask

   task automatic push1(input logic [6:0] c0, c1, c2, c3, c4);
      q1.push_back({c0, 1'b0});
      q1.push_back({c1, 1'b0});
      q1.push_back({c2, 1'b0});
      q1.push_back({c3, 1'b0});
      q1.push_back({c4, 1'b1});
   endtask

   // Renders one character on dut0 with col_ready high and checks cycle timing.
   task automatic run0(input logic [6:0] code);
      code0 = code;
      cv0   = 1'b1;
      tick();
      cv0 = 1'b0;
      chk("rom_addr", {25'd0, addr0}, {25'd0, code});
      chk("fetch_no_valid", {31'd0, cval0}, 32'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("col_valid_run", {31'd0, cval0}, 32'd1);
         chk("col_last_pos", {31'd0, clast0}, (i == 5) ? 32'd1 : 32'd0);
         tick();
      end
      chk("valid_drop_after_last", {31'd0, cval0}, 32'd0);
      chk("ready_after_last", {31'd0, cr0}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      int s;
      cv0 = 1'b0; code0 = '0; crdy0 = 1'b1;
      cv1 = 1'b0; code1 = '0;
      repeat (3) tick();
      chk("rst_char_ready", {31'd0, cr0}, 32'd0);
      chk("rst_col_valid", {31'd0, cval0}, 32'd0);
      chk("rst_col_last", {31'd0, clast0}, 32'd0);
      chk("rst_col_data", {25'd0, cd0}, 32'd0);
      chk("rst_rom_addr", {25'd0, addr0}, 32'd0);
      chk("rst_char_ready1", {31'd0, cr1}, 32'd0);
      @(negedge clk) rst = 1'b0;
      tick();
      chk("ready_after_reset", {31'd0, cr0}, 32'd1);

      push0(7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E);
      run0(7'h41);
      push0(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
      run0(7'h20);
      push0(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      run0(7'h0A);

      // Backpressure on 'H', with a competing char_valid that must be ignored.
      push0(7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F);
      code0 = 7'h48; cv0 = 1'b1; crdy0 = 1'b0;
      tick();
      code0 = 7'h20;
      for (int k = 0; k < 6; k++) begin
         t = 0;
         while (!cval0 && t < 20) begin
            tick();
            t++;
         end
         if (t >= 20) chk("bp_timeout", 32'd0, 32'd1);
         s = (k == 2 || k == 5) ? 3 : int'($urandom_range(0, 2));
         repeat (s) tick();
         if (k == 5) begin
            chk("bp_addr_held", {25'd0, addr0}, 32'h48);
            chk("bp_ready_low", {31'd0, cr0}, 32'd0);
            cv0 = 1'b0;
         end
         crdy0 = 1'b1;
         tick();
         crdy0 = 1'b0;
      end
      chk("bp_ready_after_last", {31'd0, cr0}, 32'd1);
      crdy0 = 1'b1;
      tick();
      chk("ignored_code_not_taken", {25'd0, addr0}, 32'h48);

      // Asynchronous reset while column 3 is presented.
      push0(7'h7E, 7'h09, 7'h09, 7'h09, 7'h7E);
      code0 = 7'h41; cv0 = 1'b1;
      tick();
      cv0 = 1'b0;
      repeat (4) tick();
      chk("pre_reset_valid", {31'd0, cval0}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_valid_drop", {31'd0, cval0}, 32'd0);
      chk("async_last_drop", {31'd0, clast0}, 32'd0);
      chk("async_data_clear", {25'd0, cd0}, 32'd0);
      chk("async_ready_low", {31'd0, cr0}, 32'd0);
      chk("async_addr_clear", {25'd0, addr0}, 32'd0);
      q0.delete();
      @(negedge clk) rst = 1'b0;
      tick();
      chk("ready_after_midreset", {31'd0, cr0}, 32'd1);
      push0(7'h00, 7'h41, 7'h7F, 7'h41, 7'h00);
      run0(7'h49);

      // Back-to-back on the gapless instance.
      push1(7'h7F, 7'h08, 7'h08, 7'h08, 7'h7F);
      push1(7'h00, 7'h41, 7'h7F, 7'h41, 7'h00);
      code1 = 7'h48; cv1 = 1'b1;
      tick();
      code1 = 7'h49;
      t = 0;
      while (acc1.size() < 2 && t < 50) begin
         tick();
         t++;
      end
      cv1 = 1'b0;
      t = 0;
      while (lst1.size() < 2 && t < 50) begin
         tick();
         t++;
      end
      chk("b2b_accepts", acc1.size(), 32'd2);
      chk("b2b_lasts", lst1.size(), 32'd2);
      if (acc1.size() == 2 && lst1.size() == 2) begin
         chk("b2b_accept_gap", acc1[1] - lst1[0], 32'd1);
         chk("b2b_total", lst1[1] - acc1[0] + 1, 32'd14);
      end

      repeat (3) tick();
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
